// File: rtl/approx_error_monitor.sv
// Exhaustive-sweep error monitor for approximate adders: drives every input vector,
// compares the DUT response against the exact sum and accumulates error statistics.
module approx_error_monitor #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 3,
  parameter int ET    = 5,
  parameter int LAT   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic [N_IN-1:0]         dut_in,
  input  logic [N_OUT-1:0]        dut_out,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [N_OUT-1:0]        max_err,
  output logic [N_IN+N_OUT-1:0]   err_sum,
  output logic [N_IN:0]           viol_cnt,
  output logic [N_IN-1:0]         first_viol,
  output logic                    first_viol_vld
);

  localparam int HALF = N_IN / 2;
  localparam int CW   = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [N_IN-1:0] LAST = '1;

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]          drain_cnt;
  logic                   chk_vld;
  logic [N_IN-1:0]        chk_vec;
  logic [N_OUT-1:0]       exact, abs_err;
  logic signed [N_OUT:0]  diff;
  logic                   viol, clr;
  logic [N_IN:0]          viol_cnt_nxt;

  // The check point trails issue by LAT cycles so dut_out lines up with its vector.
  generate
    if (LAT == 0) begin : g_nopipe
      assign chk_vld = (state == SWEEP);
      assign chk_vec = dut_in;
    end else begin : g_pipe
      logic [LAT-1:0]  vld_pipe;
      logic [N_IN-1:0] vec_pipe [LAT];
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_pipe <= '0;
          for (int unsigned i = 0; i < LAT; i++) vec_pipe[i] <= '0;
        end else begin
          vld_pipe[0] <= (state == SWEEP);
          vec_pipe[0] <= dut_in;
          for (int unsigned i = 1; i < LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            vec_pipe[i] <= vec_pipe[i-1];
          end
        end
      end
      assign chk_vld = vld_pipe[LAT-1];
      assign chk_vec = vec_pipe[LAT-1];
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = SWEEP;
      SWEEP: if (dut_in == LAST) state_nxt = (LAT == 0) ? DONE : DRAIN;
      DRAIN: if (int'(drain_cnt) == LAT - 1) state_nxt = DONE;
      DONE:  if (start) state_nxt = SWEEP;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    clr          = start && ((state == IDLE) || (state == DONE));
    exact        = N_OUT'(chk_vec[HALF-1:0]) + N_OUT'(chk_vec[N_IN-1:HALF]);
    diff         = $signed({1'b0, exact}) - $signed({1'b0, dut_out});
    abs_err      = diff[N_OUT] ? N_OUT'(-diff) : diff[N_OUT-1:0];
    viol         = int'(abs_err) > ET;
    viol_cnt_nxt = viol_cnt + (N_IN+1)'(chk_vld && viol);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      drain_cnt      <= '0;
      dut_in         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      max_err        <= '0;
      err_sum        <= '0;
      viol_cnt       <= '0;
      first_viol     <= '0;
      first_viol_vld <= 1'b0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt == SWEEP) || (state_nxt == DRAIN);
      done      <= (state_nxt == DONE);
      dut_in    <= (state == SWEEP) ? dut_in + N_IN'(1) : '0;
      drain_cnt <= (state == DRAIN) ? drain_cnt + CW'(1) : '0;
      // pass must see the final check, which may land on the same edge as DONE entry.
      if (state_nxt != DONE) pass <= 1'b0;
      else if (state != DONE) pass <= (viol_cnt_nxt == '0);
      if (clr) begin
        max_err        <= '0;
        err_sum        <= '0;
        viol_cnt       <= '0;
        first_viol     <= '0;
        first_viol_vld <= 1'b0;
      end else if (chk_vld) begin
        if (abs_err > max_err) max_err <= abs_err;
        err_sum  <= err_sum + (N_IN+N_OUT)'(abs_err);
        viol_cnt <= viol_cnt_nxt;
        if (viol && !first_viol_vld) begin
          first_viol     <= chk_vec;
          first_viol_vld <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_approx_error_monitor.sv
// Bench for approx_error_monitor: table of sweep scenarios against a combinational
// and a two-cycle-latency instance, plus reset and restart corner cases.
module tb_approx_error_monitor;

  logic clk = 1'b0;
  logic rst, start0, start1;
  always #5 clk = ~clk;

  logic [3:0] dut_in0, dut_in1, first_viol0, first_viol1;
  logic [2:0] dut_out0, dut_out1, max_err0, max_err1;
  logic       busy0, busy1, done0, done1, pass0, pass1, fvld0, fvld1;
  logic [6:0] err_sum0, err_sum1;
  logic [4:0] viol_cnt0, viol_cnt1;

  int mode0, mode1;
  int errors = 0;
  int checks = 0;

  approx_error_monitor #(.N_IN(4), .N_OUT(3), .ET(5), .LAT(0)) u_lat0 (
    .clk(clk), .rst(rst), .start(start0), .dut_in(dut_in0), .dut_out(dut_out0),
    .busy(busy0), .done(done0), .pass(pass0), .max_err(max_err0), .err_sum(err_sum0),
    .viol_cnt(viol_cnt0), .first_viol(first_viol0), .first_viol_vld(fvld0));

  approx_error_monitor #(.N_IN(4), .N_OUT(3), .ET(5), .LAT(2)) u_lat2 (
    .clk(clk), .rst(rst), .start(start1), .dut_in(dut_in1), .dut_out(dut_out1),
    .busy(busy1), .done(done1), .pass(pass1), .max_err(max_err1), .err_sum(err_sum1),
    .viol_cnt(viol_cnt1), .first_viol(first_viol1), .first_viol_vld(fvld1));

  function automatic logic [2:0] sum_of(input logic [3:0] v);
    return {1'b0, v[1:0]} + {1'b0, v[3:2]};
  endfunction

  // mode0: 0 exact, 1 constant 0, 2 constant 7
  always_comb begin
    case (mode0)
      1:       dut_out0 = 3'd0;
      2:       dut_out0 = 3'd7;
      default: dut_out0 = sum_of(dut_in0);
    endcase
  end

  // mode1: 0 exact delayed two registers, 1 exact delayed one register
  logic [3:0] d1, d2;
  always @(posedge clk) begin
    d1 <= dut_in1;
    d2 <= d1;
  end
  assign dut_out1 = (mode1 == 1) ? sum_of(d1) : sum_of(d2);

  typedef struct {
    int sel, mode, poke;
    int max_err, err_sum, viol, first, fvld, pass, busy_cycles;
  } vec_t;

  typedef struct {
    logic       busy, done, pass, fvld;
    logic [2:0] max_err;
    logic [6:0] err_sum;
    logic [4:0] viol_cnt;
    logic [3:0] first_viol, dut_in;
  } obs_t;

  vec_t exp_q[$];

  function automatic obs_t get_obs(input int sel);
    obs_t o;
    if (sel == 0) begin
      o.busy = busy0; o.done = done0; o.pass = pass0; o.fvld = fvld0;
      o.max_err = max_err0; o.err_sum = err_sum0; o.viol_cnt = viol_cnt0;
      o.first_viol = first_viol0; o.dut_in = dut_in0;
    end else begin
      o.busy = busy1; o.done = done1; o.pass = pass1; o.fvld = fvld1;
      o.max_err = max_err1; o.err_sum = err_sum1; o.viol_cnt = viol_cnt1;
      o.first_viol = first_viol1; o.dut_in = dut_in1;
    end
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input int sel);
    obs_t o = get_obs(sel);
    chk({tag, ".busy"}, 32'(o.busy), 0);
    chk({tag, ".done"}, 32'(o.done), 0);
    chk({tag, ".pass"}, 32'(o.pass), 0);
    chk({tag, ".max_err"}, 32'(o.max_err), 0);
    chk({tag, ".err_sum"}, 32'(o.err_sum), 0);
    chk({tag, ".viol_cnt"}, 32'(o.viol_cnt), 0);
    chk({tag, ".first_viol"}, 32'(o.first_viol), 0);
    chk({tag, ".fvld"}, 32'(o.fvld), 0);
    chk({tag, ".dut_in"}, 32'(o.dut_in), 0);
  endtask

  task automatic pulse_start(input int sel);
    @(negedge clk);
    if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic run(input string tag, input vec_t v);
    obs_t o;
    vec_t e;
    int n, bcnt;
    if (v.sel == 0) mode0 = v.mode; else mode1 = v.mode;
    exp_q.push_back(v);
    pulse_start(v.sel);
    o = get_obs(v.sel);
    chk({tag, ".done_drop"}, 32'(o.done), 0);
    chk({tag, ".pass_drop"}, 32'(o.pass), 0);
    chk({tag, ".fvld_drop"}, 32'(o.fvld), 0);
    n = 0;
    bcnt = 0;
    while (!o.done && n < 100) begin
      if (o.busy) bcnt++;
      if (v.poke != 0 && n == 5) begin
        if (v.sel == 0) start0 = 1'b1; else start1 = 1'b1;
      end
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
      n++;
      o = get_obs(v.sel);
    end
    chk({tag, ".done_seen"}, 32'(o.done), 1);
    e = exp_q.pop_front();
    chk({tag, ".busy_cycles"}, 32'(bcnt), 32'(e.busy_cycles));
    chk({tag, ".max_err"}, 32'(o.max_err), 32'(e.max_err));
    chk({tag, ".err_sum"}, 32'(o.err_sum), 32'(e.err_sum));
    chk({tag, ".viol_cnt"}, 32'(o.viol_cnt), 32'(e.viol));
    chk({tag, ".first_viol"}, 32'(o.first_viol), 32'(e.first));
    chk({tag, ".fvld"}, 32'(o.fvld), 32'(e.fvld));
    chk({tag, ".pass"}, 32'(o.pass), 32'(e.pass));
    chk({tag, ".dut_in"}, 32'(o.dut_in), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[7];
    vec_t ex;
    obs_t o;
    int n;
    //            sel mode poke max sum viol first fvld pass busy
    tbl[0] = '{0, 0, 0, 0, 0,  0, 0,  0, 1, 16};   // exact
    tbl[1] = '{0, 1, 0, 6, 48, 1, 15, 1, 0, 16};   // constant 0
    tbl[2] = '{0, 0, 0, 0, 0,  0, 0,  0, 1, 16};   // exact, restarted from DONE
    tbl[3] = '{0, 2, 0, 7, 64, 3, 0,  1, 0, 16};   // constant 7
    tbl[4] = '{0, 0, 1, 0, 0,  0, 0,  0, 1, 16};   // exact, start poked mid-sweep
    tbl[5] = '{1, 0, 0, 0, 0,  0, 0,  0, 1, 18};   // LAT=2, model delayed two
    tbl[6] = '{1, 1, 0, 6, 24, 1, 15, 1, 0, 18};   // LAT=2, model delayed one
    ex = tbl[0];

    mode0 = 0; mode1 = 0;
    start0 = 1'b0; start1 = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle("reset0", 0);
    chk_idle("reset1", 1);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run($sformatf("vec%0d", i), tbl[i]);

    // Mid-sweep reset: accumulate some error, then reset at vector 7.
    mode0 = 1;
    pulse_start(0);
    n = 0;
    while (dut_in0 != 4'd7 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("midrst.reach7", 32'(dut_in0), 7);
    chk("midrst.partial_sum", 32'(err_sum0), 12);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle("midrst", 0);
    o = get_obs(0);
    @(negedge clk);
    chk("midrst.stays_idle", 32'(busy0), 0);
    run("after_rst", ex);

    for (int i = 5; i < 7; i++) run($sformatf("vec%0d", i), tbl[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
